// File: rtl/seq_alu.sv
// Multi-cycle WIDTH-bit add/sub/mul/div unit with a start/done handshake and a double-width result.
// Define SEQ_ALU_DIV_EN to build the divider; without it op=11 completes at once with err=1.
module seq_alu #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [1:0]       op,
  input  logic             sign,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] res_hi,
  output logic [WIDTH-1:0] res_lo,
  output logic             ovf,
  output logic             dz,
  output logic             err,
  output logic [2:0]       dbg_state
);

  // Handshake: start is taken on any edge where the unit is idle or showing done
  // (done=1 with start=1 chains operations); busy marks cycles where start is
  // ignored; done is a one-cycle pulse and results hold until the next accepted start.
  localparam int CW = $clog2(WIDTH) + 1;

  typedef enum logic [2:0] {
    IDLE = 3'd0,
    MUL  = 3'd1,
    DIV  = 3'd2,
    FIX  = 3'd3,
    DONE = 3'd4
  } state_t;

  state_t state_q, state_d;

  logic               sign_q;
  logic [WIDTH-1:0]   m_q;
  logic [WIDTH+1:0]   acc_hi;
  logic [WIDTH-1:0]   acc_lo;
  logic               q_m1;
  logic [CW-1:0]      cnt;
  logic               accept;
  logic               last;

  logic [WIDTH:0]     ext_a, ext_b, as_sum;
  logic [2*WIDTH-1:0] as_res;
  logic               as_ovf;

  logic [WIDTH+1:0]   m_ext, addend, mul_sum, mul_hi_n;
  logic [WIDTH-1:0]   mul_lo_n;
  logic [2*WIDTH-1:0] product;
  logic [WIDTH:0]     prod_top;
  logic               mul_ovf;

`ifdef SEQ_ALU_DIV_EN
  logic               neg_q, rneg_q;
  logic [WIDTH-1:0]   mag_a, mag_b;
  logic [WIDTH:0]     div_sh, div_rem_n;
  logic [WIDTH+1:0]   div_diff;
  logic               div_ok;
`endif

  assign accept    = start && (state_q == IDLE || state_q == DONE);
  assign last      = (cnt == CW'(WIDTH - 1));
  assign busy      = (state_q != IDLE) && (state_q != DONE);
  assign done      = (state_q == DONE);
  assign dbg_state = state_q;

  // Add/sub runs on the live operands during the accepting edge.
  assign ext_a  = {sign & a[WIDTH-1], a};
  assign ext_b  = {sign & b[WIDTH-1], b};
  assign as_sum = op[0] ? (ext_a - ext_b) : (ext_a + ext_b);
  assign as_ovf = sign ? (as_sum[WIDTH] ^ as_sum[WIDTH-1]) : as_sum[WIDTH];
  assign as_res = sign ? {{(WIDTH-1){as_sum[WIDTH]}}, as_sum}
                       : {{(WIDTH-1){1'b0}}, as_sum};

  // One multiply step: Booth (signed) or shift-add (unsigned), then shift {acc_hi,acc_lo} right.
  assign m_ext = sign_q ? {{2{m_q[WIDTH-1]}}, m_q} : {2'b00, m_q};

  always_comb begin
    addend = '0;
    if (sign_q) begin
      case ({acc_lo[0], q_m1})
        2'b01:   addend = m_ext;
        2'b10:   addend = -m_ext;
        default: addend = '0;
      endcase
    end else if (acc_lo[0]) begin
      addend = m_ext;
    end
  end

  assign mul_sum  = acc_hi + addend;
  assign mul_hi_n = {mul_sum[WIDTH+1], mul_sum[WIDTH+1:1]};
  assign mul_lo_n = {mul_sum[0], acc_lo[WIDTH-1:1]};
  assign product  = {mul_hi_n[WIDTH-1:0], mul_lo_n};
  assign prod_top = product[2*WIDTH-1:WIDTH-1];
  assign mul_ovf  = sign_q ? ~((&prod_top) | ~(|prod_top))
                           : (|product[2*WIDTH-1:WIDTH]);

`ifdef SEQ_ALU_DIV_EN
  assign mag_a = (sign & a[WIDTH-1]) ? -a : a;
  assign mag_b = (sign & b[WIDTH-1]) ? -b : b;

  // Restoring step: acc_hi holds the partial remainder, acc_lo shifts dividend out / quotient in.
  assign div_sh    = {acc_hi[WIDTH-1:0], acc_lo[WIDTH-1]};
  assign div_diff  = {1'b0, div_sh} - {2'b00, m_q};
  assign div_ok    = ~div_diff[WIDTH+1];
  assign div_rem_n = div_ok ? div_diff[WIDTH:0] : div_sh;
`endif

  always_ff @(posedge clk) begin
    if (rst) state_q <= IDLE;
    else     state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE, DONE: begin
        state_d = IDLE;
        if (start) begin
          case (op)
            2'b10:   state_d = MUL;
`ifdef SEQ_ALU_DIV_EN
            2'b11:   state_d = (b == '0) ? DONE : DIV;
`endif
            default: state_d = DONE;
          endcase
        end
      end
      MUL: if (last) state_d = DONE;
`ifdef SEQ_ALU_DIV_EN
      DIV: if (last) state_d = FIX;
      FIX: state_d = DONE;
`endif
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      sign_q <= 1'b0;
      m_q    <= '0;
      acc_hi <= '0;
      acc_lo <= '0;
      q_m1   <= 1'b0;
      cnt    <= '0;
      res_hi <= '0;
      res_lo <= '0;
      ovf    <= 1'b0;
      dz     <= 1'b0;
      err    <= 1'b0;
`ifdef SEQ_ALU_DIV_EN
      neg_q  <= 1'b0;
      rneg_q <= 1'b0;
`endif
    end else if (accept) begin
      sign_q <= sign;
      m_q    <= a;
      acc_hi <= '0;
      acc_lo <= b;
      q_m1   <= 1'b0;
      cnt    <= '0;
      res_hi <= '0;
      res_lo <= '0;
      ovf    <= 1'b0;
      dz     <= 1'b0;
      err    <= 1'b0;
      case (op)
        2'b00, 2'b01: begin
          {res_hi, res_lo} <= as_res;
          ovf              <= as_ovf;
        end
        2'b10: ;
        default: begin
`ifdef SEQ_ALU_DIV_EN
          neg_q  <= sign & (a[WIDTH-1] ^ b[WIDTH-1]);
          rneg_q <= sign & a[WIDTH-1];
          m_q    <= mag_b;
          acc_lo <= mag_a;
          if (b == '0) begin
            res_lo <= '1;
            res_hi <= a;
            dz     <= 1'b1;
          end
`else
          err <= 1'b1;
`endif
        end
      endcase
    end else begin
      case (state_q)
        MUL: begin
          acc_hi <= mul_hi_n;
          acc_lo <= mul_lo_n;
          q_m1   <= acc_lo[0];
          cnt    <= cnt + CW'(1);
          if (last) begin
            {res_hi, res_lo} <= product;
            ovf              <= mul_ovf;
          end
        end
`ifdef SEQ_ALU_DIV_EN
        DIV: begin
          acc_hi <= {1'b0, div_rem_n};
          acc_lo <= {acc_lo[WIDTH-2:0], div_ok};
          cnt    <= cnt + CW'(1);
        end
        // Quotient truncates toward zero; remainder follows the dividend's sign.
        FIX: begin
          res_lo <= neg_q ? -acc_lo : acc_lo;
          res_hi <= rneg_q ? -acc_hi[WIDTH-1:0] : acc_hi[WIDTH-1:0];
          ovf    <= sign_q & ~neg_q & acc_lo[WIDTH-1];
        end
`endif
        default: ;
      endcase
    end
  end

endmodule
